// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch block.
// Contents: FSM state enum, buffer entry layout, default buffer depth,
// and the 32-bit word/address widths used across the fetch files.
package fetch_pkg;

  localparam int WORD_W        = 32;
  localparam int ADDR_W        = 32;
  localparam int DEFAULT_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2,
    ST_HALT    = 2'd3
  } fetch_state_e;

  // One buffered instruction together with the word address it came from.
  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Handshake bundle between the fetch unit, instruction memory and the core.
// master: fetch unit side (drives mem_req/mem_addr and out_*).
// slave : environment side (drives mem_ack/mem_rdata, redirect_*, out_ready).
interface fetch_if;
  import fetch_pkg::*;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [WORD_W-1:0] mem_rdata;

  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;

  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;

  modport master (
    output mem_req, mem_addr, out_valid, out_instr, out_pc,
    input  mem_ack, mem_rdata, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  mem_req, mem_addr, out_valid, out_instr, out_pc,
    output mem_ack, mem_rdata, redirect_valid, redirect_pc, out_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched instructions; flush dominates push/pop.
// Latency: a pushed entry is visible on rdata the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty.
// Ports: clk/rst, push+wdata, pop, flush, rdata (head), count, full, empty.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates visibility of every slot.
  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential word fetch into a DEPTH-entry buffer, with redirect.
// Latency: ack in cycle N -> instruction on out_* in cycle N+1; one request/cycle.
// Backpressure: out_ready stalls the buffer; no request is issued while it is full.
// Ports: clk, rst (sync, high), last_pc (halt address), bus (fetch_if.master:
//        mem_req/mem_addr/mem_ack/mem_rdata, redirect_valid/pc, out_valid/ready/instr/pc).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] last_pc,
  fetch_if.master           bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_req_q, mem_req_d;

  logic [CW-1:0]     count;
  logic [CW:0]       count_after;
  logic              full, empty, room;
  logic              ack, push, pop, flush;
  fetch_entry_t      wr_entry, rd_entry;

  // An ack only counts while a request is actually outstanding.
  assign ack      = bus.mem_ack & mem_req_q;
  assign flush    = bus.redirect_valid;
  assign pop      = ~empty & bus.out_ready;
  assign push     = (state_q == ST_WAIT) & ack & ~bus.redirect_valid;
  assign wr_entry = '{instr: bus.mem_rdata, pc: mem_addr_q};

  // Occupancy once this cycle's push/pop land; decides whether to keep fetching.
  assign count_after = {1'b0, count} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};
  assign room        = count_after < (CW + 1)'(DEPTH);

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .flush (flush),
    .rdata (rd_entry),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (bus.redirect_valid) fetch_pc_d = bus.redirect_pc;

    case (state_q)
      ST_IDLE: begin
        // A pop this cycle frees a slot, so the request can go out next cycle.
        if (bus.redirect_valid || !full || pop) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.redirect_valid) begin
          // Without an ack the memory still owes us a beat that must be thrown away.
          state_d = ack ? ST_WAIT : ST_DISCARD;
        end else if (ack) begin
          fetch_pc_d = mem_addr_q + ADDR_W'(1);
          if (mem_addr_q == last_pc) state_d = ST_HALT;
          else if (room)             state_d = ST_WAIT;
          else                       state_d = ST_IDLE;
        end
      end
      ST_DISCARD: begin
        if (ack) state_d = ST_WAIT;
      end
      ST_HALT: begin
        if (bus.redirect_valid) state_d = ST_WAIT;
      end
      default: state_d = ST_IDLE;
    endcase

    mem_req_d  = (state_d == ST_WAIT) || (state_d == ST_DISCARD);
    // A fresh request always targets fetch_pc; DISCARD keeps the old address on the bus.
    mem_addr_d = (state_d == ST_WAIT) ? fetch_pc_d : mem_addr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= '0;
      mem_addr_q <= '0;
      mem_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= mem_req_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.out_valid = ~empty;
  assign bus.out_instr = empty ? '0 : rd_entry.instr;
  assign bus.out_pc    = empty ? '0 : rd_entry.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic.
// Expected behaviour comes from a transaction-level model: a queue of the word
// addresses the core should see, the next fetch address, and halt/discard flags.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] last_pc;

  fetch_if bus();

  fetch_unit #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .last_pc (last_pc),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] q[$];
  logic [31:0] m_fpc;
  bit          m_stale, m_halted, m_in_reset;
  bit          prev_req, prev_ack, prev_rst;
  logic [31:0] prev_addr;
  int          obs_pops, obs_acks, wcnt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_req();
    return !m_in_reset && !m_halted && (m_stale || q.size() < DEPTH);
  endfunction

  task automatic sample_and_check();
    @(negedge clk);
    if (m_in_reset) begin
      chk("rst_mem_req",   32'(bus.mem_req),   32'd0);
      chk("rst_mem_addr",  bus.mem_addr,       32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_instr", bus.out_instr,      32'd0);
      chk("rst_out_pc",    bus.out_pc,         32'd0);
    end else begin
      chk("mem_req", 32'(bus.mem_req), 32'(model_req()));
      if (bus.mem_req && !m_stale) chk("mem_addr", bus.mem_addr, m_fpc);
      if (prev_req && !prev_ack && !prev_rst) chk("addr_hold", bus.mem_addr, prev_addr);
      chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk("out_pc",    bus.out_pc,    q[0]);
        chk("out_instr", bus.out_instr, mem_word(q[0]));
      end
    end
  endtask

  // Drive inputs for the coming posedge and advance the model to match.
  task automatic apply(input bit r, input bit a, input bit rdy, input bit rv,
                       input logic [31:0] rpc);
    bit req;
    req = model_req();
    rst                = r;
    bus.mem_ack        = a;
    bus.mem_rdata      = mem_word(bus.mem_addr);
    bus.out_ready      = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    if (!r && bus.out_valid && rdy && !rv) obs_pops++;
    if (!r && bus.mem_req && a) obs_acks++;
    if (r) begin
      q.delete();
      m_fpc = 0; m_stale = 0; m_halted = 0; m_in_reset = 1;
    end else begin
      m_in_reset = 0;
      if (rv) begin
        q.delete();
        m_fpc    = rpc;
        m_halted = 0;
        m_stale  = req && !a;
      end else begin
        if (q.size() != 0 && rdy) void'(q.pop_front());
        if (req && a) begin
          if (m_stale) m_stale = 0;
          else begin
            q.push_back(m_fpc);
            if (m_fpc == last_pc) m_halted = 1;
            m_fpc = m_fpc + 32'd1;
          end
        end
      end
    end
    prev_req = bus.mem_req; prev_ack = a; prev_addr = bus.mem_addr; prev_rst = r;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      sample_and_check();
      apply(1, 0, 0, 0, 32'd0);
    end
  endtask

  // ack_mode: 0 always, 1 after 3 wait cycles, 2 random.  rdy_mode: 0 low, 1 high, 2 random.
  task automatic run(input int n, input int ack_mode, input int rdy_mode,
                     input int redir_pct, input int rst_permil);
    bit a, rdy, rv, r;
    logic [31:0] rpc;
    for (int i = 0; i < n; i++) begin
      sample_and_check();
      case (ack_mode)
        0: a = 1;
        1: begin
          a = 0;
          if (bus.mem_req) begin
            if (wcnt == 3) begin a = 1; wcnt = 0; end
            else wcnt++;
          end else wcnt = 0;
        end
        default: a = ($urandom_range(0, 1) == 1);
      endcase
      case (rdy_mode)
        0: rdy = 0;
        1: rdy = 1;
        default: rdy = ($urandom_range(0, 9) < 6);
      endcase
      rv  = ($urandom_range(0, 99) < redir_pct);
      r   = ($urandom_range(0, 999) < rst_permil);
      rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                        : 32'($urandom_range(0, 80));
      apply(r, a, rdy, rv, rpc);
    end
  endtask

  initial begin
    wcnt = 0; obs_pops = 0; obs_acks = 0;
    prev_req = 0; prev_ack = 0; prev_rst = 1; prev_addr = 0;

    // Straight-line stream 0..5 then halt
    last_pc = 32'd5;
    apply(1, 0, 0, 0, 32'd0);
    do_reset(2);
    obs_pops = 0;
    run(14, 0, 1, 0, 0);
    chk("p1_pops", 32'(obs_pops), 32'd6);
    chk("p1_halt_req", 32'(bus.mem_req), 32'd0);

    // Buffer fills with core stalled, one pop restarts fetching
    last_pc = 32'h0000_F000;
    do_reset(2);
    obs_acks = 0;
    run(10, 0, 0, 0, 0);
    chk("p2_acks", 32'(obs_acks), 32'd4);
    chk("p2_full_req", 32'(bus.mem_req), 32'd0);
    run(1, 0, 1, 0, 0);
    sample_and_check();
    chk("p2_refill_req", 32'(bus.mem_req), 32'd1);
    apply(0, 0, 0, 0, 32'd0);
    run(10, 0, 1, 0, 0);

    // Slow memory: ack after three wait cycles
    last_pc = 32'd20;
    do_reset(2);
    wcnt = 0;
    run(40, 1, 1, 0, 0);

    // Redirect while waiting on address 2, late ack dropped
    last_pc = 32'h0000_F000;
    do_reset(2);
    sample_and_check(); apply(0, 0, 1, 0, 32'd0);
    sample_and_check(); apply(0, 1, 1, 0, 32'd0);
    sample_and_check(); apply(0, 1, 1, 0, 32'd0);
    sample_and_check(); chk("p4_addr2", bus.mem_addr, 32'd2);
    apply(0, 0, 1, 1, 32'h40);
    sample_and_check(); apply(0, 0, 1, 0, 32'd0);
    sample_and_check(); chk("p4_discard_hold", bus.mem_addr, 32'd2);
    apply(0, 1, 1, 0, 32'd0);
    sample_and_check(); chk("p4_next_addr", bus.mem_addr, 32'h40);
    apply(0, 1, 1, 0, 32'd0);
    sample_and_check(); chk("p4_out_pc", bus.out_pc, 32'h40);
    apply(0, 1, 1, 0, 32'd0);
    run(6, 0, 1, 0, 0);

    // Redirect together with a pop while three entries are buffered
    do_reset(2);
    for (int i = 0; i < 4; i++) begin
      sample_and_check(); apply(0, 1, 0, 0, 32'd0);
    end
    sample_and_check(); chk("p5_valid_before", 32'(bus.out_valid), 32'd1);
    apply(0, 0, 1, 1, 32'h100);
    sample_and_check(); chk("p5_valid_after", 32'(bus.out_valid), 32'd0);
    apply(0, 0, 1, 0, 32'd0);
    run(20, 2, 2, 0, 0);

    // Reset pulse in the middle of a request, with an ack during reset
    do_reset(2);
    run(3, 0, 1, 0, 0);
    sample_and_check(); apply(1, 1, 1, 0, 32'd0);
    sample_and_check();
    chk("p6_req_low", 32'(bus.mem_req), 32'd0);
    chk("p6_valid_low", 32'(bus.out_valid), 32'd0);
    apply(0, 1, 1, 0, 32'd0);
    sample_and_check();
    chk("p6_restart_req", 32'(bus.mem_req), 32'd1);
    chk("p6_restart_addr", bus.mem_addr, 32'd0);
    apply(0, 1, 1, 0, 32'd0);
    run(10, 0, 1, 0, 0);

    // Address wrap FFFFFFFE -> 1, reached through a discarded beat
    last_pc = 32'd1;
    do_reset(2);
    sample_and_check(); apply(0, 0, 1, 0, 32'd0);
    sample_and_check(); apply(0, 0, 1, 1, 32'hFFFF_FFFE);
    obs_pops = 0;
    run(12, 0, 1, 0, 0);
    chk("p7_wrap_pops", 32'(obs_pops), 32'd4);
    chk("p7_halt_req", 32'(bus.mem_req), 32'd0);

    // Random traffic
    last_pc = 32'd60;
    do_reset(2);
    run(4000, 2, 2, 3, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
